quadrature_decoder: RTL and testbench
=====================================

// Module: quadrature_decoder
// PURPOSE
//  - Decodes 2-channel quadrature (Gray) encoder inputs a_in/b_in into step/direction events.
//  - Accumulates position in an internal loadable up/down counter.
//  - Sits at the sensor boundary: inputs are asynchronous pins; outputs feed control/status logic.
//  - Detects illegal double-bit transitions and flags them.
// PARAMETERS
//  - CNT_WIDTH    8  width of position count and counter_in
//  - SYNC_STAGES  2  synchronizer flops per input (min 2)
//  - FILTER_LEN   4  stable-sample count, used only with QDEC_FILTER_EN (min 2)
// PORTS
//  - clk          in   1          single clock, rising edge
//  - reset_n      in   1          asynchronous, active-low reset
//  - a_in         in   1          encoder channel A, asynchronous
//  - b_in         in   1          encoder channel B, asynchronous
//  - load_en      in   1          load counter_in into count
//  - counter_in   in   CNT_WIDTH  load value
//  - err_clr      in   1          clears err_sticky
//  - count        out  CNT_WIDTH  position, modulo 2^CNT_WIDTH
//  - dir          out  1          last step direction: 1 = up, 0 = down
//  - step_pulse   out  1          1-cycle pulse per decoded legal step
//  - err_pulse    out  1          1-cycle pulse per illegal transition
//  - err_sticky   out  1          set by any error, held until err_clr
// BEHAVIOUR
//  - Reset: all outputs 0; sync flops 0; prev_ab 00; FSM in INIT.
//  - FSM INIT: lasts SYNC_STAGES+1 cycles (+FILTER_LEN when filtered).
//    - prev_ab tracks the accepted AB value; no steps or errors decoded.
//    - Then moves to RUN. Pins static at 11 across reset therefore produce no error.
//  - FSM RUN: each cycle compare accepted AB (cur) with prev_ab, then prev_ab <= cur.
//    - 00->01->11->10->00 = up; reverse order = down; unchanged = no event.
//    - Both bits change (00<->11, 01<->10) = error: err_pulse=1, err_sticky=1.
//      No count change; dir holds.
//  - Step: step_pulse=1, dir=step direction, count +/-1.
//    - Wraps 2^CNT_WIDTH-1 -> 0 on up, 0 -> 2^CNT_WIDTH-1 on down.
//  - Latency (unfiltered): edge k is the first clock edge sampling the new pin level.
//    - count, step_pulse and dir update on edge k+SYNC_STAGES.
//  - load_en: count <= counter_in next edge; has priority over a same-cycle step.
//    - step_pulse and dir still report that step; count = counter_in exactly.
//    - Legal in INIT and RUN.
//  - err_clr in the same cycle as a new error: set wins, err_sticky stays 1.
//  - Async reset mid-operation: immediate return to reset values and INIT.
// CONFIGURATION
//  - QDEC_FILTER_EN defined:
//    - A synchronized AB value is accepted as cur only after FILTER_LEN consecutive identical samples.
//    - Shorter glitches are ignored entirely.
//    - Adds FILTER_LEN cycles of latency.
//  - QDEC_FILTER_EN undefined: the synchronized AB feeds the decoder directly; no filter logic.
// STRUCTURE
//  - Shared package qdec_pkg:
//    - FSM state encodings: ST_INIT, ST_RUN.
//    - Gray step constants: DIR_UP = 1'b1, DIR_DOWN = 1'b0.
//    - Combinational decode function: returns {valid, err, dir} from prev/cur 2-bit values.
//  - One sub-module qdec_sync: SYNC_STAGES-deep reset-to-0 synchronizer, width 2, instantiated once.
//  - Filter, FSM, decode and position counter live in quadrature_decoder.
// TESTING
//  1. Reset, AB=00, then AB 01,11,10,00 with each level held 6 cycles.
//     -> count 0->4, 4 step_pulses, dir=1, no err.
//  2. From count=4, AB sequence 10,11,01,00 -> count 0, dir=0.
//     Then 4 further down steps -> count wraps 0->252 (CNT_WIDTH=8).
//  3. Pins at 11 through reset release -> no err_pulse; count 0; FSM reaches RUN.
//  4. AB 00->11 in RUN -> err_pulse 1 cycle, err_sticky=1, count unchanged.
//     Then err_clr=1 while a second 01->10 error occurs -> err_sticky stays 1.
//     err_clr alone next cycle -> 0.
//  5. load_en=1, counter_in=8'hF0, same cycle as a decoded up step
//     -> count=F0, step_pulse=1, dir=1. Next up step -> F1.
//  6. QDEC_FILTER_EN, FILTER_LEN=4: a 2-cycle glitch on A -> no step.
//     A held 4+ cycles -> one step, latency SYNC_STAGES+FILTER_LEN.

Source files
------------

// File: rtl/qdec_pkg.sv
// ============================================================================
// qdec_pkg : shared FSM states, direction constants and Gray-step decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

package qdec_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Position of an AB value along the 00->01->11->10 cycle.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  // Returns {valid, err, dir}; a difference of two positions is a double-bit change.
  function automatic logic [2:0] qdec_decode(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] diff;
    diff = gray_pos(cur_ab) - gray_pos(prev_ab);
    case (diff)
      2'd1:    return {1'b1, 1'b0, DIR_UP};
      2'd3:    return {1'b1, 1'b0, DIR_DOWN};
      2'd2:    return {1'b0, 1'b1, DIR_DOWN};
      default: return 3'b000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/qdec_sync.sv
// ============================================================================
// qdec_sync : STAGES-deep reset-to-0 synchronizer for the asynchronous pins.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module qdec_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q = r_stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/quadrature_decoder.sv
// ============================================================================
// quadrature_decoder : quadrature pins -> step/dir/error events and position.
// Optional glitch filter enabled by defining QDEC_FILTER_EN.   Revision : 1.0
// ============================================================================
`default_nettype none

module quadrature_decoder
  import qdec_pkg::*;
#(
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 a_in,
  input  logic                 b_in,
  input  logic                 load_en,
  input  logic [CNT_WIDTH-1:0] counter_in,
  input  logic                 err_clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 dir,
  output logic                 step_pulse,
  output logic                 err_pulse,
  output logic                 err_sticky
);

`ifdef QDEC_FILTER_EN
  localparam int INIT_CYCLES = SYNC_STAGES + 1 + FILTER_LEN;
`else
  localparam int INIT_CYCLES = SYNC_STAGES + 1;
`endif
  localparam int INIT_W = $clog2(INIT_CYCLES + 1);

  generate
    if (SYNC_STAGES < 2 || FILTER_LEN < 2) begin : g_param_check
      $error("quadrature_decoder: SYNC_STAGES and FILTER_LEN must be >= 2");
    end
  endgenerate

  logic [1:0]        w_sync_ab;
  logic [1:0]        w_cur_ab;
  logic [1:0]        r_prev_ab;
  logic [2:0]        w_dec;
  logic              w_decode_en;
  logic              w_step;
  logic              w_err;
  state_t            r_state;
  state_t            w_next_state;
  logic [INIT_W-1:0] r_init_cnt;

  qdec_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (2)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({a_in, b_in}),
    .q       (w_sync_ab)
  );

`ifdef QDEC_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  logic [1:0]       r_flt_last;
  logic [1:0]       r_cur_ab;
  logic [FLT_W-1:0] r_flt_cnt;

  // r_flt_cnt counts consecutive identical samples; accept on the FILTER_LEN-th.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flt_last <= 2'b00;
      r_cur_ab   <= 2'b00;
      r_flt_cnt  <= '0;
    end else if (w_sync_ab != r_flt_last) begin
      r_flt_last <= w_sync_ab;
      r_flt_cnt  <= FLT_W'(1);
    end else begin
      if (r_flt_cnt < FLT_W'(FILTER_LEN)) r_flt_cnt <= r_flt_cnt + FLT_W'(1);
      if (r_flt_cnt == FLT_W'(FILTER_LEN - 1)) r_cur_ab <= w_sync_ab;
    end
  end

  assign w_cur_ab = r_cur_ab;
`else
  assign w_cur_ab = w_sync_ab;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_INIT;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_decode_en  = 1'b0;
    case (r_state)
      ST_INIT: if (r_init_cnt == INIT_W'(INIT_CYCLES - 1)) w_next_state = ST_RUN;
      ST_RUN:  w_decode_en = 1'b1;
      default: w_next_state = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              r_init_cnt <= '0;
    else if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + INIT_W'(1);
  end

  assign w_dec  = qdec_decode(r_prev_ab, w_cur_ab);
  assign w_step = w_decode_en & w_dec[2];
  assign w_err  = w_decode_en & w_dec[1];

  // prev_ab follows the accepted value in INIT too, so the first RUN compare is clean.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_ab  <= 2'b00;
      count      <= '0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      r_prev_ab  <= w_cur_ab;
      step_pulse <= w_step;
      err_pulse  <= w_err;
      if (w_step) dir <= w_dec[0];
      if (load_en)
        count <= counter_in;
      else if (w_step)
        count <= (w_dec[0] == DIR_UP) ? count + CNT_WIDTH'(1) : count - CNT_WIDTH'(1);
      if (w_err)        err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_quadrature_decoder.sv
// ============================================================================
// tb_quadrature_decoder : vector table, corner sequences and random pins vs
// a pin-history reference model.   Revision : 1.0
// ============================================================================
`default_nettype none

module tb_quadrature_decoder;

  localparam int CW = 8;
  localparam int S  = 2;
  localparam int F  = 4;
`ifdef QDEC_FILTER_EN
  localparam int FL       = F;
  localparam int INIT_CYC = S + 1 + F;
  localparam int LAT      = S + F;
`else
  localparam int FL       = 1;
  localparam int INIT_CYC = S + 1;
  localparam int LAT      = S;
`endif
  localparam int HOLD = LAT + 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_in = 1'b0, b_in = 1'b0;
  logic          load_en = 1'b0, err_clr = 1'b0;
  logic [CW-1:0] counter_in = '0;
  logic [CW-1:0] count;
  logic          dir, step_pulse, err_pulse, err_sticky;

  always #5 clk = ~clk;

  quadrature_decoder #(.CNT_WIDTH(CW), .SYNC_STAGES(S), .FILTER_LEN(F)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .a_in       (a_in),
    .b_in       (b_in),
    .load_en    (load_en),
    .counter_in (counter_in),
    .err_clr    (err_clr),
    .count      (count),
    .dir        (dir),
    .step_pulse (step_pulse),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int step_seen = 0;

  // Reference: pin level seen at each clock edge since reset, and the value the
  // decoder has accepted after each edge.
  logic [1:0]    hist [0:8191];
  logic [1:0]    acc  [0:8191];
  int            t = 0;
  logic [CW-1:0] m_count;
  logic          m_dir, m_step, m_err, m_sticky;

  function automatic logic [1:0] hist_at(int i);
    return (i < 1) ? 2'b00 : hist[i];
  endfunction

  function automatic logic [1:0] acc_at(int i);
    return (i < 1) ? 2'b00 : acc[i];
  endfunction

  function automatic logic [1:0] cur_at(int i);
    return (FL == 1) ? hist_at(i - S) : acc_at(i - 1);
  endfunction

  function automatic int pos(logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  task automatic set_ab(input logic [1:0] v);
    a_in = v[1];
    b_in = v[0];
  endtask

  task automatic tick();
    logic [1:0] s0;
    logic       eq;
    int         d;
    @(posedge clk);
    t++;
    hist[t] = {a_in, b_in};
    s0 = hist_at(t - S);
    eq = 1'b1;
    for (int k = 1; k < FL; k++) if (hist_at(t - S - k) != s0) eq = 1'b0;
    acc[t] = eq ? s0 : acc_at(t - 1);
    m_step = 1'b0;
    m_err  = 1'b0;
    if (t > INIT_CYC) begin
      d = (pos(cur_at(t)) - pos(cur_at(t - 1)) + 4) % 4;
      m_step = (d == 1) || (d == 3);
      m_err  = (d == 2);
      if (m_step) m_dir = (d == 1);
    end
    if (load_en)     m_count = counter_in;
    else if (m_step) m_count = (d == 1) ? m_count + 8'd1 : m_count - 8'd1;
    if (m_err)        m_sticky = 1'b1;
    else if (err_clr) m_sticky = 1'b0;
    #1;
    chk("count", 32'(count), 32'(m_count));
    chk("dir", 32'(dir), 32'(m_dir));
    chk("step_pulse", 32'(step_pulse), 32'(m_step));
    chk("err_pulse", 32'(err_pulse), 32'(m_err));
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
    if (step_pulse) step_seen++;
  endtask

  task automatic do_reset(input logic [1:0] pins);
    reset_n = 1'b0;
    set_ab(pins);
    #2;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_flags", {28'h0, dir, step_pulse, err_pulse, err_sticky}, 32'h0);
    t = 0;
    m_count = '0; m_dir = 1'b0; m_step = 1'b0; m_err = 1'b0; m_sticky = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]    ab;
    logic [CW-1:0] exp_count;
    logic          exp_dir;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{2'b01, 8'd1,   1'b1};
    vecs[1]  = '{2'b11, 8'd2,   1'b1};
    vecs[2]  = '{2'b10, 8'd3,   1'b1};
    vecs[3]  = '{2'b00, 8'd4,   1'b1};
    vecs[4]  = '{2'b10, 8'd3,   1'b0};
    vecs[5]  = '{2'b11, 8'd2,   1'b0};
    vecs[6]  = '{2'b01, 8'd1,   1'b0};
    vecs[7]  = '{2'b00, 8'd0,   1'b0};
    vecs[8]  = '{2'b10, 8'd255, 1'b0};
    vecs[9]  = '{2'b11, 8'd254, 1'b0};
    vecs[10] = '{2'b01, 8'd253, 1'b0};
    vecs[11] = '{2'b00, 8'd252, 1'b0};

    // Up four steps, down four to zero, then wrap below zero.
    do_reset(2'b00);
    repeat (INIT_CYC + 2) tick();
    for (int i = 0; i < 12; i++) begin
      set_ab(vecs[i].ab);
      repeat (HOLD) tick();
      chk("tbl_count", 32'(count), 32'(vecs[i].exp_count));
      chk("tbl_dir", 32'(dir), 32'(vecs[i].exp_dir));
      chk("tbl_no_err", 32'(err_sticky), 32'h0);
      if (i == 3) chk("tbl_step_cnt", step_seen, 4);
    end

    // Pins at 11 through reset release, then a down step proves RUN.
    do_reset(2'b11);
    repeat (INIT_CYC + 6) tick();
    chk("p11_sticky", 32'(err_sticky), 32'h0);
    chk("p11_count", 32'(count), 32'h0);
    set_ab(2'b01);
    repeat (HOLD) tick();
    chk("p11_step", 32'(count), 32'd255);

    // Illegal transitions and err_clr priority.
    set_ab(2'b00);
    repeat (HOLD) tick();
    set_ab(2'b11);
    repeat (LAT) tick();
    tick();
    chk("err_pulse", 32'(err_pulse), 32'h1);
    chk("err_sticky", 32'(err_sticky), 32'h1);
    chk("err_count", 32'(count), 32'd254);
    tick();
    chk("err_pulse_1cyc", 32'(err_pulse), 32'h0);
    set_ab(2'b01);
    repeat (HOLD) tick();
    set_ab(2'b10);
    repeat (LAT) tick();
    err_clr = 1'b1;
    tick();
    chk("err_set_wins", 32'(err_sticky), 32'h1);
    tick();
    chk("err_clr", 32'(err_sticky), 32'h0);
    err_clr = 1'b0;

    // Load in the same cycle as an up step (10 -> 00).
    set_ab(2'b00);
    repeat (LAT) tick();
    load_en = 1'b1;
    counter_in = 8'hF0;
    tick();
    chk("ld_count", 32'(count), 32'hF0);
    chk("ld_step", 32'(step_pulse), 32'h1);
    chk("ld_dir", 32'(dir), 32'h1);
    load_en = 1'b0;
    repeat (HOLD) tick();
    set_ab(2'b01);
    repeat (HOLD) tick();
    chk("ld_next", 32'(count), 32'hF1);

`ifdef QDEC_FILTER_EN
    // Two-cycle glitch on A is swallowed; a held level steps after LAT edges.
    begin
      int s0;
      s0 = step_seen;
      set_ab(2'b11);
      tick(); tick();
      set_ab(2'b01);
      repeat (HOLD + 4) tick();
      chk("flt_glitch", step_seen, s0);
      set_ab(2'b11);
      repeat (LAT) tick();
      chk("flt_early", 32'(step_pulse), 32'h0);
      tick();
      chk("flt_step", 32'(step_pulse), 32'h1);
      chk("flt_count", 32'(count), 32'hF2);
    end
`endif

    // Random pins (legal and illegal), loads, clears, one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(2'($urandom_range(0, 3)));
      set_ab(2'($urandom_range(0, 3)));
      load_en    = ($urandom_range(0, 7) == 0);
      counter_in = 8'($urandom);
      err_clr    = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(1, 4)) tick();
    end
    load_en = 1'b0;
    err_clr = 1'b0;
    repeat (HOLD) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
